// File: rtl/cnn_mem_pkg.sv
// Shared types and default geometry for the CNN memory responder.
package cnn_mem_pkg;

  localparam int FEAT_AW_DEF = 12;
  localparam int WGT_AW_DEF  = 16;
  localparam int DW_DEF      = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_F = 3'd2,
    ST_RUN    = 3'd3,
    ST_DUMP   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/cnn_mem_bank.sv
// 1R1W synchronous RAM, read-first, one-cycle read latency; read register clears on reset.
// Define CNN_MEM_FWD_EN to return the write data on a same-address read/write.
module cnn_mem_bank #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // array storage is deliberately not reset so contents survive a responder reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // read data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
`ifdef CNN_MEM_FWD_EN
    end else if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
`endif
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cnn_mem_responder.sv
// Memory-side responder: host preload of weight/feature banks, processor access, feature dump stream.
// Optional macro CNN_MEM_FWD_EN selects write-first behaviour on the processor ports.
module cnn_mem_responder
  import cnn_mem_pkg::*;
#(
  parameter int FEAT_AW = FEAT_AW_DEF,
  parameter int WGT_AW  = WGT_AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [DW-1:0]      ld_data,
  input  logic               ld_last,
  output logic               start,
  input  logic [FEAT_AW-1:0] feature_addr,
  input  logic [DW-1:0]      feature_data,
  input  logic               feature_mem_en,
  output logic [DW-1:0]      feature_idata,
  input  logic [WGT_AW-1:0]  weight_addr,
  input  logic [DW-1:0]      weight_data,
  input  logic               weight_mem_en,
  output logic [DW-1:0]      weight_idata,
  input  logic               instruction_finish,
  output logic               dp_valid,
  input  logic               dp_ready,
  output logic [FEAT_AW-1:0] dp_addr,
  output logic [DW-1:0]      dp_data,
  output logic               dp_last,
  output logic               busy
);

  state_e             r_state, w_state_nxt;
  logic [WGT_AW-1:0]  r_ld_ptr;
  logic [FEAT_AW-1:0] r_dp_addr, w_dp_addr_nxt;
  logic               r_ld_ready, r_start, r_busy, r_dp_valid, r_dp_last;
  logic               w_ld_fire, w_dump_adv;
  logic               w_f_we, w_w_we;
  logic [FEAT_AW-1:0] w_f_waddr, w_f_raddr;
  logic [WGT_AW-1:0]  w_w_waddr;
  logic [DW-1:0]      w_f_wdata, w_w_wdata, w_f_rdata, w_w_rdata;

  assign w_ld_fire  = ld_valid && r_ld_ready;
  assign w_dump_adv = (r_state == ST_DUMP) && r_dp_valid && dp_ready;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and next dump address
  always_comb begin
    w_state_nxt   = r_state;
    w_dp_addr_nxt = r_dp_addr;
    case (r_state)
      ST_IDLE: begin
        if (ld_valid) w_state_nxt = ST_LOAD_W;
        else          w_state_nxt = ST_IDLE;
      end
      ST_LOAD_W: begin
        if (w_ld_fire && ld_last) w_state_nxt = ST_LOAD_F;
        else                      w_state_nxt = ST_LOAD_W;
      end
      ST_LOAD_F: begin
        if (w_ld_fire && ld_last) w_state_nxt = ST_RUN;
        else                      w_state_nxt = ST_LOAD_F;
      end
      ST_RUN: begin
        if (instruction_finish) begin
          w_state_nxt   = ST_DUMP;
          w_dp_addr_nxt = '0;
        end else begin
          w_state_nxt   = ST_RUN;
        end
      end
      ST_DUMP: begin
        if (w_dump_adv && r_dp_last) begin
          w_state_nxt   = ST_DONE;
        end else if (w_dump_adv) begin
          w_dp_addr_nxt = r_dp_addr + FEAT_AW'(1);
        end else begin
          w_state_nxt   = ST_DUMP;
        end
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // bank port steering: host load owns the write port while loading, processor only in RUN
  always_comb begin
    w_f_we    = 1'b0;
    w_f_waddr = feature_addr;
    w_f_wdata = feature_data;
    w_w_we    = 1'b0;
    w_w_waddr = weight_addr;
    w_w_wdata = weight_data;
    if (r_state == ST_LOAD_W) begin
      w_w_we    = w_ld_fire;
      w_w_waddr = r_ld_ptr;
      w_w_wdata = ld_data;
    end else if (r_state == ST_LOAD_F) begin
      w_f_we    = w_ld_fire;
      w_f_waddr = r_ld_ptr[FEAT_AW-1:0];
      w_f_wdata = ld_data;
    end else if (r_state == ST_RUN) begin
      w_f_we    = feature_mem_en;
      w_w_we    = weight_mem_en;
    end else begin
      w_f_we    = 1'b0;
      w_w_we    = 1'b0;
    end
  end

  // read ahead to the word the dump will present next cycle, so there are no bubbles
  assign w_f_raddr = ((r_state == ST_DUMP) || ((r_state == ST_RUN) && instruction_finish)) ?
                     w_dp_addr_nxt : feature_addr;

  // registered handshake/status outputs derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_ready <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_dp_valid <= 1'b0;
      r_dp_last  <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      r_ld_ready <= (w_state_nxt == ST_LOAD_W) || (w_state_nxt == ST_LOAD_F);
      r_start    <= (w_state_nxt == ST_RUN);
      r_busy     <= is_busy(w_state_nxt);
      r_dp_valid <= (w_state_nxt == ST_DUMP);
      r_dp_last  <= (w_state_nxt == ST_DUMP) && (w_dp_addr_nxt == {FEAT_AW{1'b1}});
      r_dp_addr  <= w_dp_addr_nxt;
    end
  end

  // load pointer, restarting at each bank boundary and wrapping silently at the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_ptr <= '0;
    end else if (w_ld_fire && ld_last) begin
      r_ld_ptr <= '0;
    end else if (w_ld_fire) begin
      r_ld_ptr <= r_ld_ptr + WGT_AW'(1);
    end else begin
      r_ld_ptr <= r_ld_ptr;
    end
  end

  cnn_mem_bank #(.AW(FEAT_AW), .DW(DW)) u_feat_bank (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_f_we),
    .i_waddr (w_f_waddr),
    .i_wdata (w_f_wdata),
    .i_raddr (w_f_raddr),
    .o_rdata (w_f_rdata)
  );

  cnn_mem_bank #(.AW(WGT_AW), .DW(DW)) u_wgt_bank (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_w_we),
    .i_waddr (w_w_waddr),
    .i_wdata (w_w_wdata),
    .i_raddr (weight_addr),
    .o_rdata (w_w_rdata)
  );

  assign ld_ready      = r_ld_ready;
  assign start         = r_start;
  assign busy          = r_busy;
  assign dp_valid      = r_dp_valid;
  assign dp_last       = r_dp_last;
  assign dp_addr       = r_dp_addr;
  assign dp_data       = w_f_rdata;
  assign feature_idata = w_f_rdata;
  assign weight_idata  = w_w_rdata;

endmodule

// File: tb/tb_cnn_mem_responder.sv
// Directed + randomized bench for cnn_mem_responder against an array-based memory model.
module tb_cnn_mem_responder;

  localparam int FAW    = 12;
  localparam int WAW    = 16;
  localparam int DW     = 32;
  localparam int FDEPTH = 4096;
  localparam int WMOD   = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           ld_valid, ld_ready, ld_last;
  logic [DW-1:0]  ld_data;
  logic           start;
  logic [FAW-1:0] feature_addr;
  logic [DW-1:0]  feature_data, feature_idata;
  logic           feature_mem_en;
  logic [WAW-1:0] weight_addr;
  logic [DW-1:0]  weight_data, weight_idata;
  logic           weight_mem_en;
  logic           instruction_finish;
  logic           dp_valid, dp_ready, dp_last, busy;
  logic [FAW-1:0] dp_addr;
  logic [DW-1:0]  dp_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fmod [FDEPTH];
  logic [31:0] wmod [WMOD];

  always #5 clk = ~clk;

  cnn_mem_responder #(.FEAT_AW(FAW), .WGT_AW(WAW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .start(start),
    .feature_addr(feature_addr), .feature_data(feature_data),
    .feature_mem_en(feature_mem_en), .feature_idata(feature_idata),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .weight_mem_en(weight_mem_en), .weight_idata(weight_idata),
    .instruction_finish(instruction_finish),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_addr(dp_addr),
    .dp_data(dp_data), .dp_last(dp_last), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_start"},    32'(start),    32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_dp_valid"}, 32'(dp_valid), 32'd0);
    chk({tag, "_dp_last"},  32'(dp_last),  32'd0);
    chk({tag, "_dp_addr"},  32'(dp_addr),  32'd0);
    chk({tag, "_dp_data"},  dp_data,       32'd0);
    chk({tag, "_fidata"},   feature_idata, 32'd0);
    chk({tag, "_widata"},   weight_idata,  32'd0);
  endtask

  // offer one load word and wait (bounded) until it is accepted
  task automatic send_word(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while ((ld_ready !== 1'b1) && (t < 20)) begin
      tick();
      t++;
    end
    chk("ld_ready_wait", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int fa, input int wa);
    feature_addr = FAW'(fa);
    weight_addr  = WAW'(wa);
    tick();
    chk({tag, "_f"}, feature_idata, fmod[fa]);
    chk({tag, "_w"}, weight_idata,  wmod[wa]);
  endtask

  initial begin
    logic [31:0] d, expv;
    int idx, cyc;

    reset = 1'b1;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    feature_addr = '0; feature_data = '0; feature_mem_en = 1'b0;
    weight_addr = '0; weight_data = '0; weight_mem_en = 1'b0;
    instruction_finish = 1'b0; dp_ready = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // three weight words then two feature words
    for (int i = 0; i < 3; i++) begin
      d = $urandom; wmod[i] = d;
      send_word(d, i == 2);
    end
    for (int i = 0; i < 2; i++) begin
      d = $urandom; fmod[i] = d;
      send_word(d, i == 1);
      if (i == 0) chk("start_before_last", 32'(start), 32'd0);
    end
    chk("start_run", 32'(start), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    chk("ld_ready_run", 32'(ld_ready), 32'd0);
    rd_check("rd_load_a2b1", 1, 2);

    // processor write then read back
    feature_addr = FAW'(5); feature_data = 32'hDEADBEEF; feature_mem_en = 1'b1;
    tick();
    feature_mem_en = 1'b0; fmod[5] = 32'hDEADBEEF;
    tick();
    chk("wr_then_rd", feature_idata, 32'hDEADBEEF);

    // same-cycle write and read of one address
    feature_data = 32'h12345678; feature_mem_en = 1'b1;
    tick();
    feature_mem_en = 1'b0;
`ifdef CNN_MEM_FWD_EN
    expv = 32'h12345678;
`else
    expv = 32'hDEADBEEF;
`endif
    chk("same_cycle_rw", feature_idata, expv);
    fmod[5] = 32'h12345678;

    // fill the whole feature bank and the modelled weight window with random data
    for (int i = 0; i < FDEPTH; i++) begin
      feature_addr = FAW'(i); feature_data = $urandom; feature_mem_en = 1'b1;
      fmod[i] = feature_data;
      weight_addr = WAW'(i % WMOD); weight_data = $urandom; weight_mem_en = (i < WMOD);
      if (i < WMOD) wmod[i] = weight_data;
      tick();
    end
    feature_mem_en = 1'b0; weight_mem_en = 1'b0;

    // random mixed reads/writes on both banks
    for (int k = 0; k < 200; k++) begin
      int fa, wa;
      logic fe, we;
      logic [31:0] fd, wd, fexp, wexp;
      fa = $urandom_range(0, 31); wa = $urandom_range(0, WMOD - 1);
      fe = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      fd = $urandom; wd = $urandom;
      feature_addr = FAW'(fa); feature_data = fd; feature_mem_en = fe;
      weight_addr = WAW'(wa); weight_data = wd; weight_mem_en = we;
      fexp = fmod[fa]; wexp = wmod[wa];
`ifdef CNN_MEM_FWD_EN
      if (fe) fexp = fd;
      if (we) wexp = wd;
`endif
      tick();
      chk("rand_f", feature_idata, fexp);
      chk("rand_w", weight_idata, wexp);
      if (fe) fmod[fa] = fd;
      if (we) wmod[wa] = wd;
    end
    feature_mem_en = 1'b0; weight_mem_en = 1'b0;

    // dump under a 1010 ready pattern
    instruction_finish = 1'b1;
    tick();
    instruction_finish = 1'b0;
    chk("dump_start", 32'(start), 32'd0);
    chk("dump_busy", 32'(busy), 32'd1);
    idx = 0; cyc = 0;
    while ((idx < FDEPTH) && (cyc < 20000)) begin
      dp_ready = (cyc % 2 == 0);
      chk("dp_valid", 32'(dp_valid), 32'd1);
      chk("dp_addr", 32'(dp_addr), 32'(idx));
      chk("dp_data", dp_data, fmod[idx]);
      chk("dp_last", 32'(dp_last), 32'(idx == FDEPTH - 1));
      if (dp_ready) idx++;
      tick();
      cyc++;
    end
    dp_ready = 1'b0;
    chk("dump_count", 32'(idx), 32'(FDEPTH));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valid", 32'(dp_valid), 32'd0);
    chk("done_start", 32'(start), 32'd0);

    // second session: stray controls during load must have no effect
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    d = $urandom; wmod[0] = d; send_word(d, 1'b0);
    instruction_finish = 1'b1;
    tick();
    instruction_finish = 1'b0;
    chk("lw_finish_ready", 32'(ld_ready), 32'd1);
    chk("lw_finish_start", 32'(start), 32'd0);
    d = $urandom; wmod[1] = d; send_word(d, 1'b1);
    d = $urandom; fmod[0] = d; send_word(d, 1'b0);
    feature_addr = FAW'(200); feature_data = ~fmod[200]; feature_mem_en = 1'b1;
    weight_addr = WAW'(40); weight_data = ~wmod[40]; weight_mem_en = 1'b1;
    tick();
    feature_mem_en = 1'b0; weight_mem_en = 1'b0;
    chk("lf_en_ready", 32'(ld_ready), 32'd1);
    chk("lf_en_start", 32'(start), 32'd0);
    d = $urandom; fmod[1] = d; send_word(d, 1'b0);
    d = $urandom; fmod[2] = d; send_word(d, 1'b1);
    chk("run2_start", 32'(start), 32'd1);
    rd_check("lf_no_write", 200, 40);
    rd_check("run2_rd", 2, 1);

    // dump with continuous ready, reset at address 100
    instruction_finish = 1'b1;
    tick();
    instruction_finish = 1'b0;
    dp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("dp2_addr", 32'(dp_addr), 32'(i));
      chk("dp2_data", dp_data, fmod[i]);
      tick();
    end
    chk("dp2_at100", 32'(dp_addr), 32'd100);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    dp_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_busy", 32'(busy), 32'd0);

    // reload overwrites from address 0 only
    d = $urandom; wmod[0] = d; send_word(d, 1'b1);
    d = $urandom; fmod[0] = d; send_word(d, 1'b1);
    chk("run3_start", 32'(start), 32'd1);
    rd_check("reload_0", 0, 0);
    rd_check("keep_1", 1, 1);
    rd_check("keep_300", 300, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
